// File: rtl/tcam_pkg.sv
// Shared constants and helpers for the TCAM longest-prefix search engine.
// State encodings are plain constants so older tools and checkers can bind to them.
package tcam_pkg;

    localparam int TCAM_WIDTH      = 32;
    localparam int TCAM_ENTRIES    = 32;
    localparam int TCAM_INDEX_SIZE = 5;
    localparam int TCAM_LANES      = 8;
    localparam int TCAM_LEN_W      = 6;
    localparam int NGROUPS         = TCAM_ENTRIES / TCAM_LANES;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Lengths beyond the key width behave as a full-width compare.
    function automatic logic [TCAM_LEN_W-1:0] len_clamp(input logic [TCAM_LEN_W-1:0] len);
        return (len > TCAM_LEN_W'(TCAM_WIDTH)) ? TCAM_LEN_W'(TCAM_WIDTH) : len;
    endfunction

    // Built one bit wider than the key so that len==0 yields an all-zero mask.
    function automatic logic [TCAM_WIDTH-1:0] prefix_mask(input logic [TCAM_LEN_W-1:0] len);
        logic [TCAM_WIDTH:0] m;
        m = ~(((TCAM_WIDTH+1)'(1) << (TCAM_LEN_W'(TCAM_WIDTH) - len_clamp(len)))
              - (TCAM_WIDTH+1)'(1));
        return m[TCAM_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/tcam_lane_match.sv
// Compares one group of lines against the key and reports the longest local match.
// On equal lengths the lowest offset is kept.
module tcam_lane_match
    import tcam_pkg::*;
#(
    parameter int LANES = TCAM_LANES,
    parameter int OFF_W = $clog2(TCAM_LANES)
) (
    input  logic [TCAM_WIDTH-1:0]       i_key,
    input  logic [LANES*TCAM_WIDTH-1:0] i_val,
    input  logic [LANES*TCAM_LEN_W-1:0] i_len,
    input  logic [LANES-1:0]            i_valid,
    output logic                        o_hit,
    output logic [TCAM_LEN_W-1:0]       o_len,
    output logic [OFF_W-1:0]            o_off
);

    logic [TCAM_WIDTH-1:0] w_val;
    logic [TCAM_WIDTH-1:0] w_mask;
    logic [TCAM_LEN_W-1:0] w_clen;
    logic                  w_match;

    always_comb begin
        o_hit   = 1'b0;
        o_len   = '0;
        o_off   = '0;
        w_val   = '0;
        w_mask  = '0;
        w_clen  = '0;
        w_match = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            w_val   = i_val[i*TCAM_WIDTH +: TCAM_WIDTH];
            w_clen  = len_clamp(i_len[i*TCAM_LEN_W +: TCAM_LEN_W]);
            w_mask  = prefix_mask(w_clen);
            w_match = i_valid[i] && ((i_key & w_mask) == (w_val & w_mask));
            // Strict compare keeps the earlier lane on a tie.
            if (w_match && (!o_hit || (w_clen > o_len))) begin
                o_hit = 1'b1;
                o_len = w_clen;
                o_off = OFF_W'(i);
            end
        end
    end

endmodule

// File: rtl/tcam_search_d1.sv
// Longest-prefix search over the TCAM entry memory, LANES lines per cycle.
// go/done handshake: go is sampled only in IDLE; done pulses for one cycle with final index/found.
module tcam_search_d1
    import tcam_pkg::*;
#(
    parameter int WIDTH      = TCAM_WIDTH,
    parameter int ENTRIES    = TCAM_ENTRIES,
    parameter int INDEX_SIZE = TCAM_INDEX_SIZE,
    parameter int LANES      = TCAM_LANES,
    parameter int LEN_W      = TCAM_LEN_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     go,
    input  logic [WIDTH-1:0]         key,
    input  logic [ENTRIES*WIDTH-1:0] entry_val,
    input  logic [ENTRIES*LEN_W-1:0] entry_len,
    input  logic [ENTRIES-1:0]       entry_valid,
    output logic [INDEX_SIZE-1:0]    index,
    output logic                     found,
    output logic                     done
);

    localparam int GRP_W = $clog2(NGROUPS);
    localparam int OFF_W = $clog2(LANES);

    logic [1:0]            r_state;
    logic [GRP_W-1:0]      r_grp;
    logic [WIDTH-1:0]      r_key;
    logic                  r_hit;
    logic [LEN_W-1:0]      r_best_len;
    logic [INDEX_SIZE-1:0] r_best_idx;
    logic [INDEX_SIZE-1:0] r_index;
    logic                  r_found;
    logic                  r_done;

    logic [LANES*WIDTH-1:0] w_grp_val;
    logic [LANES*LEN_W-1:0] w_grp_len;
    logic [LANES-1:0]       w_grp_valid;
    logic                   w_hit;
    logic [LEN_W-1:0]       w_len;
    logic [OFF_W-1:0]       w_off;
    logic                   w_take;
    logic                   w_last;
    logic                   w_nxt_hit;
    logic [LEN_W-1:0]       w_nxt_len;
    logic [INDEX_SIZE-1:0]  w_nxt_idx;

    // Entry buses are read live for the group currently being scanned.
    assign w_grp_val   = entry_val[int'(r_grp)*(LANES*WIDTH) +: LANES*WIDTH];
    assign w_grp_len   = entry_len[int'(r_grp)*(LANES*LEN_W) +: LANES*LEN_W];
    assign w_grp_valid = entry_valid[int'(r_grp)*LANES +: LANES];

    tcam_lane_match #(
        .LANES (LANES),
        .OFF_W (OFF_W)
    ) u_lane_match (
        .i_key   (r_key),
        .i_val   (w_grp_val),
        .i_len   (w_grp_len),
        .i_valid (w_grp_valid),
        .o_hit   (w_hit),
        .o_len   (w_len),
        .o_off   (w_off)
    );

    // Earlier groups win ties, so a later group must be strictly longer.
    always_comb begin
        w_take    = w_hit && (!r_hit || (w_len > r_best_len));
        w_nxt_hit = r_hit | w_hit;
        w_nxt_len = w_take ? w_len : r_best_len;
        w_nxt_idx = w_take ? {r_grp, w_off} : r_best_idx;
        w_last    = (r_grp == GRP_W'(NGROUPS-1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_grp      <= '0;
            r_key      <= '0;
            r_hit      <= 1'b0;
            r_best_len <= '0;
            r_best_idx <= '0;
            r_index    <= '0;
            r_found    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (go) begin
                        r_key      <= key;
                        r_hit      <= 1'b0;
                        r_best_len <= '0;
                        r_best_idx <= '0;
                        r_grp      <= '0;
                        r_state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    r_hit      <= w_nxt_hit;
                    r_best_len <= w_nxt_len;
                    r_best_idx <= w_nxt_idx;
                    r_grp      <= r_grp + GRP_W'(1);
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_index <= w_nxt_idx;
                        r_found <= w_nxt_hit;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign index = r_index;
    assign found = r_found;
    assign done  = r_done;

endmodule

// File: tb/tb_tcam_search_d1.sv
// Randomised and directed bench for tcam_search_d1 with a queue-based scoreboard
// fed by a longest-prefix reference model.
module tb_tcam_search_d1;

    localparam int W  = 32;
    localparam int E  = 32;
    localparam int LW = 6;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            go = 1'b0;
    logic [W-1:0]    key = '0;
    logic [E*W-1:0]  entry_val = '0;
    logic [E*LW-1:0] entry_len = '0;
    logic [E-1:0]    entry_valid = '0;
    logic [4:0]      index;
    logic            found;
    logic            done;

    tcam_search_d1 dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .go          (go),
        .key         (key),
        .entry_val   (entry_val),
        .entry_len   (entry_len),
        .entry_valid (entry_valid),
        .index       (index),
        .found       (found),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   idx;
        logic fnd;
        int   cyc;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] m_val[E];
    int           m_len[E];
    bit           m_vld[E];
    int           cyc = 0;
    int           next_free = 0;
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: scan every line, keep the longest matching prefix, first seen on ties.
    function automatic exp_t model(input logic [W-1:0] k);
        exp_t r;
        int   best = -1;
        int   best_len = -1;
        int   l;
        bit   m;
        for (int i = 0; i < E; i++) begin
            if (m_vld[i]) begin
                l = (m_len[i] > W) ? W : m_len[i];
                m = (l == 0) || ((k >> (W - l)) == (m_val[i] >> (W - l)));
                if (m && l > best_len) begin
                    best_len = l;
                    best = i;
                end
            end
        end
        r.fnd = (best >= 0);
        r.idx = (best >= 0) ? best : 0;
        r.cyc = 0;
        return r;
    endfunction

    // Acceptance model: a go is taken once the engine has been free for a cycle.
    always @(posedge clk) begin
        exp_t e;
        if (!reset_n) begin
            next_free = 0;
        end else if (go && cyc >= next_free) begin
            e = model(key);
            e.cyc = cyc + 5;
            exp_q.push_back(e);
            next_free = cyc + 6;
        end
        cyc++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending search (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("found", int'(found), int'(e.fnd));
                chk("index", int'(index), e.idx);
                chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic apply_entries();
        for (int i = 0; i < E; i++) begin
            entry_val[i*W +: W]    = m_val[i];
            entry_len[i*LW +: LW]  = LW'(m_len[i]);
            entry_valid[i]         = m_vld[i];
        end
    endtask

    task automatic clear_entries();
        for (int i = 0; i < E; i++) begin
            m_val[i] = '0;
            m_len[i] = 0;
            m_vld[i] = 1'b0;
        end
    endtask

    task automatic do_go(input logic [W-1:0] k);
        key = k;
        go  = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got %0d pending searches expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] base;
        clear_entries();
        apply_entries();
        #1;
        chk("reset_index", int'(index), 0);
        chk("reset_found", int'(found), 0);
        chk("reset_done", int'(done), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single hit
        m_val[5] = 32'hC0A80000; m_len[5] = 16; m_vld[5] = 1'b1;
        apply_entries();
        do_go(32'hC0A80101);
        wait_idle();
        chk("t2_index", int'(index), 5);
        chk("t2_found", int'(found), 1);

        // Reset mid-scan
        do_go(32'hC0A80101);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("midscan_index", int'(index), 0);
        chk("midscan_found", int'(found), 0);
        chk("midscan_done", int'(done), 0);
        exp_q.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Longest prefix
        clear_entries();
        m_val[3]  = 32'h0A000000; m_len[3]  = 8;  m_vld[3]  = 1'b1;
        m_val[20] = 32'h0A010000; m_len[20] = 16; m_vld[20] = 1'b1;
        m_val[30] = 32'h0A010200; m_len[30] = 24; m_vld[30] = 1'b1;
        apply_entries();
        do_go(32'h0A010203);
        wait_idle();
        chk("t3a_index", int'(index), 30);
        do_go(32'h0A01FF00);
        wait_idle();
        chk("t3b_index", int'(index), 20);

        // Back-to-back with go held, then a stray go during SCAN
        go = 1'b1;
        key = 32'h0A010203;
        repeat (20) @(posedge clk);
        #1 go = 1'b0;
        wait_idle();
        do_go(32'h0A01FF00);
        @(posedge clk);
        #1 go = 1'b1;
        key = 32'h0A000000;
        @(posedge clk);
        #1 go = 1'b0;
        wait_idle();

        // Tie on default routes
        clear_entries();
        m_vld[9] = 1'b1;
        m_vld[2] = 1'b1;
        apply_entries();
        do_go($urandom);
        wait_idle();
        chk("t4_index", int'(index), 2);
        chk("t4_found", int'(found), 1);

        // Full miss
        for (int i = 0; i < E; i++) begin
            m_val[i] = 32'hFFFFFFFF;
            m_len[i] = 32;
            m_vld[i] = 1'b1;
        end
        apply_entries();
        do_go(32'h0);
        wait_idle();
        chk("t5_found", int'(found), 0);
        chk("t5_index", int'(index), 0);

        // Random prefixes clustered around a base so hits and ties are common
        for (int t = 0; t < 40; t++) begin
            base = $urandom;
            for (int i = 0; i < E; i++) begin
                m_vld[i] = ($urandom_range(0, 3) != 0);
                m_len[i] = ($urandom_range(0, 3) == 0) ? 16 : int'($urandom_range(0, 40));
                m_val[i] = base ^ ($urandom >> $urandom_range(0, 32));
            end
            apply_entries();
            do_go(base ^ ($urandom >> $urandom_range(4, 32)));
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
